player_bullet: RTL and testbench

- Drives the bullet into the invader formation block and consumes its hit flag.
- Latches the cannon column on a fire press and launches a single bullet just above the player row.
- Climbs the bullet one row per movement tick, retiring it on a hit or when it leaves the top row.
- Keeps a saturating score of confirmed hits for the display and score logic.

---
 rtl/player_bullet_pkg.sv | 12 +
 rtl/bullet_tick_gen.sv | 16 +
 rtl/player_bullet.sv | 84 ++++++++
 tb/tb_player_bullet.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/player_bullet_pkg.sv
// player_bullet_pkg: state encoding and playfield constants shared by the bullet logic.
package player_bullet_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;
  localparam int NUM_COLS = 20;
  localparam logic [4:0] MAX_COL = 5'd19;
  localparam logic [3:0] NO_BULLET_ROW = 4'd0;
  localparam logic [3:0] PLAYER_ROW = 4'd15;
endpackage

// File: rtl/bullet_tick_gen.sv
// bullet_tick_gen: one-cycle movement tick every SPEED clocks, realignable by restart.
module bullet_tick_gen #(
  parameter int SPEED = 100000
) (
  input  logic i_clk_25MHz,
  input  logic i_reset_n,
  input  logic restart,
  output logic tick
);
  localparam int W = SPEED > 1 ? $clog2(SPEED) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(SPEED - 1);
  always_ff @(posedge i_clk_25MHz or negedge i_reset_n)
    if (!i_reset_n) cnt <= '0;
    else cnt <= restart || tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/player_bullet.sv
// player_bullet: fires, climbs and retires the player's single bullet and keeps a saturating hit score.
module player_bullet
  import player_bullet_pkg::*;
#(
  parameter int SPEED          = 100000,
  parameter int COOLDOWN_TICKS = 2,
  parameter int LAUNCH_ROW     = 14
) (
  input  logic       i_clk_25MHz,
  input  logic       i_reset_n,
  input  logic       i_fire,
  input  logic [4:0] i_player_x,
  input  logic       i_hit,
  output logic [4:0] o_bullet_x,
  output logic [3:0] o_bullet_y,
  output logic       o_bullet_active,
  output logic       o_shot_done,
  output logic [7:0] o_score
);
  state_t state;
  logic fire_meta, fire_sync, fire_prev, fire_pulse, hit_prev, hit_pulse, tick, launch, retire;
  logic [7:0] cd_cnt;
  assign hit_pulse = i_hit && !hit_prev;
  assign launch = state == IDLE && fire_pulse;
  assign retire = state == FLYING && (hit_pulse || (tick && o_bullet_y <= 4'd1));
  bullet_tick_gen #(.SPEED(SPEED)) u_tick (
    .i_clk_25MHz(i_clk_25MHz),
    .i_reset_n  (i_reset_n),
    .restart    (launch),
    .tick       (tick)
  );
  // fire is asynchronous: two-flop synchroniser, then a registered edge pulse
  always_ff @(posedge i_clk_25MHz or negedge i_reset_n)
    if (!i_reset_n) begin
      fire_meta  <= 1'b0;
      fire_sync  <= 1'b0;
      fire_prev  <= 1'b0;
      fire_pulse <= 1'b0;
      hit_prev   <= 1'b0;
    end else begin
      fire_meta  <= i_fire;
      fire_sync  <= fire_meta;
      fire_prev  <= fire_sync;
      fire_pulse <= fire_sync && !fire_prev;
      hit_prev   <= i_hit;
    end
  always_ff @(posedge i_clk_25MHz or negedge i_reset_n)
    if (!i_reset_n) begin
      state           <= IDLE;
      cd_cnt          <= '0;
      o_bullet_x      <= '0;
      o_bullet_y      <= NO_BULLET_ROW;
      o_bullet_active <= 1'b0;
      o_shot_done     <= 1'b0;
      o_score         <= '0;
    end else begin
      o_shot_done <= retire;
      case (state)
        IDLE: begin
          o_bullet_y <= launch ? 4'(LAUNCH_ROW) : NO_BULLET_ROW;
          if (launch) begin
            o_bullet_x      <= i_player_x > MAX_COL ? MAX_COL : i_player_x;
            o_bullet_active <= 1'b1;
            state           <= FLYING;
          end
        end
        FLYING:
          if (retire) begin
            o_bullet_y      <= NO_BULLET_ROW;
            o_bullet_active <= 1'b0;
            o_score         <= hit_pulse && o_score != 8'hff ? o_score + 8'd1 : o_score;
            cd_cnt          <= 8'(COOLDOWN_TICKS);
            state           <= COOLDOWN;
          end else if (tick) o_bullet_y <= o_bullet_y - 4'd1;
        COOLDOWN:
          if (cd_cnt == 8'd0) state <= IDLE;
          else if (tick) begin
            cd_cnt <= cd_cnt - 8'd1;
            if (cd_cnt == 8'd1) state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_player_bullet.sv
// tb_player_bullet: directed checks of launch, climb, miss, hit, lockout, clamp, saturation and async reset.
module tb_player_bullet;
  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_fire = 1'b0;
  logic [4:0] i_player_x = '0;
  logic       i_hit = 1'b0;
  logic [4:0] o_bullet_x;
  logic [3:0] o_bullet_y;
  logic       o_bullet_active;
  logic       o_shot_done;
  logic [7:0] o_score;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  player_bullet #(.SPEED(4), .COOLDOWN_TICKS(2), .LAUNCH_ROW(14)) dut (
    .i_clk_25MHz    (clk),
    .i_reset_n      (i_reset_n),
    .i_fire         (i_fire),
    .i_player_x     (i_player_x),
    .i_hit          (i_hit),
    .o_bullet_x     (o_bullet_x),
    .o_bullet_y     (o_bullet_y),
    .o_bullet_active(o_bullet_active),
    .o_shot_done    (o_shot_done),
    .o_score        (o_score)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // leaves the bench at the first falling edge after the launch edge
  task automatic launch(input logic [4:0] x);
    int lat;
    i_fire = 1'b0;
    i_player_x = x;
    cyc(4);
    i_fire = 1'b1;
    lat = 0;
    while (!o_bullet_active && lat < 10) begin
      cyc(1);
      lat++;
    end
    i_fire = 1'b0;
    chk("launch_active", o_bullet_active, 1);
    chk("launch_y", o_bullet_y, 14);
  endtask
  initial begin
    cyc(2);
    chk("rst_x", o_bullet_x, 0);
    chk("rst_y", o_bullet_y, 0);
    chk("rst_active", o_bullet_active, 0);
    chk("rst_done", o_shot_done, 0);
    chk("rst_score", o_score, 0);
    i_reset_n = 1'b1;
    cyc(2);
    chk("idle_y", o_bullet_y, 0);
    // single miss: climb 14..1, one row per 4 cycles
    launch(5'd7);
    chk("miss_x", o_bullet_x, 7);
    for (int r = 14; r >= 1; r--)
      for (int j = 0; j < 4; j++) begin
        chk("miss_climb_y", o_bullet_y, r);
        chk("miss_climb_active", o_bullet_active, 1);
        cyc(1);
      end
    chk("miss_y", o_bullet_y, 0);
    chk("miss_active", o_bullet_active, 0);
    chk("miss_done", o_shot_done, 1);
    chk("miss_score", o_score, 0);
    // press during cooldown and keep holding: must never launch
    i_fire = 1'b1;
    cyc(1);
    chk("miss_done_pulse", o_shot_done, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      chk("lockout_cooldown", o_bullet_active, 0);
    end
    // first fresh press after idle launches; presses in flight are dropped
    launch(5'd3);
    chk("hit_x", o_bullet_x, 3);
    i_player_x = 5'd10;
    cyc(2);
    i_fire = 1'b1;
    cyc(15);
    chk("hit_latch_x", o_bullet_x, 3);
    chk("hit_pre_y", o_bullet_y, 10);
    chk("hit_pre_active", o_bullet_active, 1);
    i_hit = 1'b1;
    cyc(1);
    chk("hit_y", o_bullet_y, 0);
    chk("hit_active", o_bullet_active, 0);
    chk("hit_done", o_shot_done, 1);
    chk("hit_score", o_score, 1);
    for (int i = 0; i < 49; i++) begin
      cyc(1);
      chk("hit_hold_score", o_score, 1);
    end
    chk("hit_hold_done", o_shot_done, 0);
    i_hit = 1'b0;
    i_fire = 1'b0;
    cyc(2);
    i_hit = 1'b1;
    cyc(2);
    chk("stray_hit_score", o_score, 1);
    chk("stray_hit_active", o_bullet_active, 0);
    i_hit = 1'b0;
    cyc(12);
    // column clamp and latch, then hit arriving in the tick cycle
    launch(5'd25);
    chk("clamp_x", o_bullet_x, 19);
    i_player_x = 5'd0;
    cyc(20);
    chk("clamp_hold_x", o_bullet_x, 19);
    cyc(3);
    chk("coll_pre_y", o_bullet_y, 9);
    i_hit = 1'b1;
    cyc(1);
    chk("coll_y", o_bullet_y, 0);
    chk("coll_active", o_bullet_active, 0);
    chk("coll_done", o_shot_done, 1);
    chk("coll_score", o_score, 2);
    i_hit = 1'b0;
    cyc(12);
    // saturation: hits 3..256
    for (int n = 3; n <= 256; n++) begin
      launch(5'd1);
      i_hit = 1'b1;
      cyc(1);
      chk("sat_score", o_score, n > 255 ? 255 : n);
      i_hit = 1'b0;
      cyc(12);
    end
    chk("sat_final", o_score, 255);
    // async reset mid-flight at y=8
    launch(5'd5);
    cyc(24);
    chk("arst_pre_y", o_bullet_y, 8);
    #2 i_reset_n = 1'b0;
    #1;
    chk("arst_y", o_bullet_y, 0);
    chk("arst_active", o_bullet_active, 0);
    chk("arst_score", o_score, 0);
    chk("arst_x", o_bullet_x, 0);
    @(negedge clk);
    i_reset_n = 1'b1;
    launch(5'd6);
    chk("post_arst_x", o_bullet_x, 6);
    chk("post_arst_score", o_score, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
